bit_serial_alu: RTL and testbench
=================================

BIT_SERIAL_ALU -- requirements
Module: bit_serial_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand set present.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand set.
REQ-006 SHALL have port op  input  2  operation: 00 ADD, 01 SUB, 10 ADDC, 11 SUBB.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port cin  input  1  carry-in for ADDC; borrow-in for SUBB.
REQ-010 SHALL have port out_valid  output  1  result and flags valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port result  output  WIDTH  operation result, modulo 2^WIDTH.
REQ-013 SHALL have port cout  output  1  final carry out of MSB (SUB/SUBB: 1 = no borrow).
REQ-014 SHALL have port overflow  output  1  signed two's-complement overflow.
REQ-015 SHALL have port zero  output  1  result == 0.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE); both driven only from state.
REQ-017 SHALL, in IDLE, on in_valid && in_ready, capture a, b, op, cin, clear the bit counter and result shift register, and move to SHIFT; otherwise remain in IDLE.
REQ-018 SHALL form the effective second operand and initial carry at capture: ADD b,0; SUB ~b,1; ADDC b,cin; SUBB ~b,~cin.
REQ-019 SHALL, in SHIFT, process exactly one bit per cycle, LSB first: sum bit = a0^b0^c, carry = majority(a0,b0,c); sum bit shifted into result register from MSB side; operands shifted right by 1.
REQ-020 SHALL count bits 0..WIDTH-1; on the edge processing bit WIDTH-1, register result, cout, overflow (carry into MSB XOR carry out of MSB) and zero, and move to DONE.
REQ-021 SHALL assert out_valid exactly WIDTH cycles after the accepting edge (WIDTH=8: accept edge N, out_valid high from edge N+8).
REQ-022 SHALL, in DONE, hold result and flags stable while out_ready is low; on out_ready high, move to IDLE (in_ready high the next cycle).
REQ-023 SHALL ignore in_valid, a, b, op, cin in SHIFT and DONE; no operand set accepted the same cycle a result is consumed.
REQ-024 SHALL keep result and flags unchanged from DONE exit until the next DONE entry.
REQ-025 SHALL treat out_ready as don't-care outside DONE.

Reset
REQ-026 SHALL, when rst is high at a rising edge, set state IDLE, counter 0, operand and shift registers 0, result 0, cout 0, overflow 0, zero 0; hence out_valid 0, in_ready 1.
REQ-027 SHALL, if rst asserts mid-SHIFT or in DONE, abort the operation with no result delivered; rst has priority over all other inputs.

Verification
REQ-028 SHALL cover (WIDTH=8) ADD a=8'h7F b=8'h01 -> result 8'h80, cout 0, overflow 1, zero 0, out_valid exactly 8 cycles after accept.
REQ-029 SHALL cover SUB a=8'h05 b=8'h07 -> result 8'hFE, cout 0, overflow 0; and SUB a=8'h10 b=8'h10 -> result 8'h00, cout 1, zero 1.
REQ-030 SHALL cover ADDC a=8'hFF b=8'h00 cin=1 -> result 8'h00, cout 1, zero 1; SUBB a=8'h80 b=8'h00 cin=1 -> result 8'h7F, overflow 1.
REQ-031 SHALL cover backpressure: out_ready low 5 cycles in DONE with in_valid high and changing a/b -> result/flags stable, in_ready 0, no new capture; out_ready high -> IDLE next cycle.
REQ-032 SHALL cover reset at bit 3 of SHIFT -> next cycle out_valid 0, in_ready 1, result 0; following ADD 8'h03+8'h04 -> 8'h07.
REQ-033 SHALL cover WIDTH=2 and WIDTH=32 with random ops against a reference model, including back-to-back transactions with out_ready held high.

Source files
------------

// File: rtl/bit_serial_alu.sv
// Bit-serial add/subtract unit.
// One operand set is accepted in IDLE, its bits are combined LSB first, one
// per clock, in SHIFT, and the registered result plus flags are offered in
// DONE until the consumer takes them.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE and out_valid only in DONE. Once
// a side asserts valid, it holds valid and its payload until that transfer.
module bit_serial_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // op encoding: bit 0 selects subtract, bit 1 selects use of cin
   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_ADDC = 2'b10;
   localparam logic [1:0] OP_SUBB = 2'b11;

   state_t           state;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [WIDTH-1:0] sum_sh;

   logic [WIDTH-1:0] b_eff;
   logic             carry_init;
   logic             sum_bit;
   logic             carry_next;
   logic [WIDTH-1:0] sum_sh_next;
   logic             last_bit;

   // Handshake flags follow the state register directly.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Effective second operand and starting carry. Subtraction is a + ~b + 1.
   // Borrow-in is the inverted carry, so SUBB starts with ~cin.
   always_comb begin
      b_eff      = b;
      carry_init = 1'b0;
      case (op)
         OP_ADD: begin
            b_eff      = b;
            carry_init = 1'b0;
         end
         OP_SUB: begin
            b_eff      = ~b;
            carry_init = 1'b1;
         end
         OP_ADDC: begin
            b_eff      = b;
            carry_init = cin;
         end
         OP_SUBB: begin
            b_eff      = ~b;
            carry_init = ~cin;
         end
         default: begin
            b_eff      = b;
            carry_init = 1'b0;
         end
      endcase
   end

   // One full-adder slice per cycle. The new sum bit enters at the MSB, so
   // after WIDTH shifts bit 0 has reached position 0.
   always_comb begin
      sum_bit     = a_sh[0] ^ b_sh[0] ^ carry;
      carry_next  = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
      sum_sh_next = {sum_bit, sum_sh[WIDTH-1:1]};
      last_bit    = (bit_cnt == LAST_BIT);
   end

   // Control FSM and datapath registers. Reset takes priority over all inputs
   // and discards any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         a_sh     <= '0;
         b_sh     <= '0;
         carry    <= 1'b0;
         sum_sh   <= '0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh    <= a;
                  b_sh    <= b_eff;
                  carry   <= carry_init;
                  bit_cnt <= '0;
                  sum_sh  <= '0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               carry   <= carry_next;
               sum_sh  <= sum_sh_next;
               bit_cnt <= bit_cnt + CW'(1);
               if (last_bit) begin
                  // carry still holds the carry into the MSB, so it can be
                  // compared with the carry out of the MSB to get overflow.
                  result   <= sum_sh_next;
                  cout     <= carry_next;
                  overflow <= carry ^ carry_next;
                  zero     <= ~|sum_sh_next;
                  bit_cnt  <= '0;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serial_alu.sv
// Testbench for bit_serial_alu with three instances: WIDTH 8, 2 and 32.
// The expected results come from an arithmetic model of add/subtract, with
// carry, borrow and signed-overflow rules applied to whole numbers.
module tb_bit_serial_alu;

   logic        clk;
   logic        rst;
   logic [2:0]  in_valid_v;
   logic [2:0]  in_ready_v;
   logic [2:0]  out_valid_v;
   logic [2:0]  out_ready_v;
   logic [2:0]  cout_v;
   logic [2:0]  ovf_v;
   logic [2:0]  zero_v;
   logic [1:0]  op_d;
   logic [31:0] a_d;
   logic [31:0] b_d;
   logic        cin_d;
   logic [7:0]  res8;
   logic [1:0]  res2;
   logic [31:0] res32;

   int n_cmp;
   int n_err;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   bit_serial_alu #(.WIDTH(8)) u_alu8 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .op(op_d), .a(a_d[7:0]), .b(b_d[7:0]), .cin(cin_d),
      .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .result(res8),
      .cout(cout_v[0]), .overflow(ovf_v[0]), .zero(zero_v[0])
   );

   bit_serial_alu #(.WIDTH(2)) u_alu2 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .op(op_d), .a(a_d[1:0]), .b(b_d[1:0]), .cin(cin_d),
      .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .result(res2),
      .cout(cout_v[1]), .overflow(ovf_v[1]), .zero(zero_v[1])
   );

   bit_serial_alu #(.WIDTH(32)) u_alu32 (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
      .op(op_d), .a(a_d), .b(b_d), .cin(cin_d),
      .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .result(res32),
      .cout(cout_v[2]), .overflow(ovf_v[2]), .zero(zero_v[2])
   );

   function automatic int width_of(input int sel);
      case (sel)
         0:       return 8;
         1:       return 2;
         default: return 32;
      endcase
   endfunction

   function automatic logic [31:0] get_res(input int sel);
      case (sel)
         0:       return {24'b0, res8};
         1:       return {30'b0, res2};
         default: return res32;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: integer arithmetic on the operand values.
   task automatic model(input int w, input logic [1:0] op_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, input logic cin_i,
                        output logic [31:0] r, output logic co, output logic ov,
                        output logic z);
      longint m, half, ua, ub, ci, full, sa, sb, s;
      logic   is_add;
      m      = (longint'(1) << w) - 1;
      half   = longint'(1) << (w - 1);
      ua     = {32'b0, a_i} & m;
      ub     = {32'b0, b_i} & m;
      ci     = op_i[1] ? longint'(cin_i) : 0;
      is_add = ~op_i[0];
      full   = is_add ? (ua + ub + ci) : (ua - ub - ci);
      r      = 32'(full & m);
      co     = is_add ? (full > m) : (full >= 0);
      sa     = (ua >= half) ? ua - (m + 1) : ua;
      sb     = (ub >= half) ? ub - (m + 1) : ub;
      s      = is_add ? (sa + sb + ci) : (sa - sb - ci);
      ov     = (s > half - 1) || (s < -half);
      z      = (r == 0);
   endtask

   // Driver: one full transaction on instance sel. Called and returning at
   // 1 ns after a rising edge. hold = number of DONE cycles with out_ready low.
   task automatic run_txn(input int sel, input logic [1:0] op_i, input logic [31:0] a_i,
                          input logic [31:0] b_i, input logic cin_i, input int hold);
      logic [31:0] exp_r;
      logic        exp_c, exp_v, exp_z;
      int          w, lat;
      string       pfx;
      w   = width_of(sel);
      pfx = $sformatf("w%0d op%0d a=%0h b=%0h c=%0d", w, op_i, a_i, b_i, cin_i);
      model(w, op_i, a_i, b_i, cin_i, exp_r, exp_c, exp_v, exp_z);

      out_ready_v[sel] = (hold == 0);
      op_d  = op_i;
      a_d   = a_i;
      b_d   = b_i;
      cin_d = cin_i;
      in_valid_v[sel] = 1'b1;
      chk({pfx, " in_ready"}, 32'(in_ready_v[sel]), 32'd1);
      @(posedge clk); #1;
      in_valid_v[sel] = 1'b0;
      a_d = $urandom;
      b_d = $urandom;

      lat = 0;
      while (!out_valid_v[sel] && lat < 80) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({pfx, " latency"}, 32'(lat), 32'(w));
      chk({pfx, " result"}, get_res(sel), exp_r);
      chk({pfx, " cout"}, 32'(cout_v[sel]), 32'(exp_c));
      chk({pfx, " overflow"}, 32'(ovf_v[sel]), 32'(exp_v));
      chk({pfx, " zero"}, 32'(zero_v[sel]), 32'(exp_z));

      for (int i = 0; i < hold; i++) begin
         in_valid_v[sel] = 1'b1;
         a_d = $urandom;
         b_d = $urandom;
         op_d = 2'($urandom_range(0, 3));
         @(posedge clk); #1;
         chk({pfx, " hold out_valid"}, 32'(out_valid_v[sel]), 32'd1);
         chk({pfx, " hold in_ready"}, 32'(in_ready_v[sel]), 32'd0);
         chk({pfx, " hold result"}, get_res(sel), exp_r);
         chk({pfx, " hold flags"}, {29'b0, cout_v[sel], ovf_v[sel], zero_v[sel]},
             {29'b0, exp_c, exp_v, exp_z});
      end
      if (hold > 0) begin
         out_ready_v[sel] = 1'b1;
         @(posedge clk); #1;
         // in_valid stayed high through the consuming edge; no capture allowed
         chk({pfx, " post in_ready"}, 32'(in_ready_v[sel]), 32'd1);
         in_valid_v[sel] = 1'b0;
      end else begin
         @(posedge clk); #1;
         chk({pfx, " post in_ready"}, 32'(in_ready_v[sel]), 32'd1);
      end
      chk({pfx, " post out_valid"}, 32'(out_valid_v[sel]), 32'd0);
      chk({pfx, " post result"}, get_res(sel), exp_r);
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      rst         = 1'b1;
      in_valid_v  = '0;
      out_ready_v = '1;
      op_d        = '0;
      a_d         = '0;
      b_d         = '0;
      cin_d       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state of all instances
      chk("rst in_ready", {29'b0, in_ready_v}, 32'h7);
      chk("rst out_valid", {29'b0, out_valid_v}, 32'h0);
      chk("rst flags", {23'b0, cout_v, ovf_v, zero_v}, 32'h0);
      chk("rst res8", {24'b0, res8}, 32'h0);
      chk("rst res32", res32, 32'h0);

      // directed WIDTH=8 cases
      run_txn(0, 2'b00, 32'h7F, 32'h01, 1'b0, 0);
      run_txn(0, 2'b01, 32'h05, 32'h07, 1'b0, 0);
      run_txn(0, 2'b01, 32'h10, 32'h10, 1'b0, 0);
      run_txn(0, 2'b10, 32'hFF, 32'h00, 1'b1, 0);
      run_txn(0, 2'b11, 32'h80, 32'h00, 1'b1, 0);
      // backpressure: 5 DONE cycles with out_ready low
      run_txn(0, 2'b00, 32'h7F, 32'h01, 1'b0, 5);

      // reset during bit 3 of SHIFT
      run_txn(0, 2'b00, 32'h12, 32'h34, 1'b0, 0);
      op_d  = 2'b00;
      a_d   = 32'h55;
      b_d   = 32'h22;
      cin_d = 1'b0;
      in_valid_v[0] = 1'b1;
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst out_valid", 32'(out_valid_v[0]), 32'd0);
      chk("midrst in_ready", 32'(in_ready_v[0]), 32'd1);
      chk("midrst result", {24'b0, res8}, 32'h0);
      repeat (10) @(posedge clk);
      #1;
      chk("midrst no result", 32'(out_valid_v[0]), 32'd0);
      run_txn(0, 2'b00, 32'h03, 32'h04, 1'b0, 0);

      // boundary cases for the narrow and wide instances
      run_txn(1, 2'b00, 32'h1, 32'h1, 1'b0, 0);
      run_txn(1, 2'b01, 32'h0, 32'h1, 1'b0, 0);
      run_txn(1, 2'b11, 32'h2, 32'h0, 1'b1, 0);
      run_txn(2, 2'b00, 32'hFFFF_FFFF, 32'h1, 1'b0, 0);
      run_txn(2, 2'b01, 32'h8000_0000, 32'h1, 1'b0, 0);
      run_txn(2, 2'b10, 32'h7FFF_FFFF, 32'h0, 1'b1, 0);

      // randomized, mostly back-to-back with out_ready held high
      for (int sel = 0; sel < 3; sel++) begin
         for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            int          hold;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = '1;
            if ($urandom_range(0, 7) == 0) rb = '0;
            hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_txn(sel, 2'($urandom_range(0, 3)), ra, rb, 1'($urandom_range(0, 1)), hold);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
